// File: rtl/nes_vga_pkg.sv
// Shared constants, payload types and the NES master palette for the VGA scaler.
package nes_vga_pkg;

    localparam int unsigned NES_W  = 256;
    localparam int unsigned NES_H  = 240;
    localparam int unsigned VGA_W  = 640;
    localparam int unsigned VGA_H  = 2 * NES_H;

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned RGB_W  = 3 * CH_W;
    localparam int unsigned XCNT_W = 10;
    localparam int unsigned YCNT_W = 9;
    localparam int unsigned COL_W  = 8;
    localparam int unsigned ROW_W  = 8;
    localparam int unsigned PAL_N  = 64;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    // One pipeline tap of the timing signals plus the window qualifier.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_n;
        logic win;
    } tap_t;

    localparam tap_t TAP_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0, win: 1'b0};

    // 2C02 master palette; the unused "black" slots are all zero.
    localparam logic [RGB_W-1:0] NES_PALETTE [PAL_N] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

endpackage

// File: rtl/nes_palette_rom.sv
// Combinational 64x24 lookup of a 6-bit NES palette index to RGB.
module nes_palette_rom
    import nes_vga_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output rgb_t             rgb_c_o
);

    assign rgb_c_o = rgb_t'(NES_PALETTE[idx_i]);

endmodule

// File: rtl/nes_vga_scaler.sv
// 2x NES-to-VGA pixel stage: counts raster position, fetches the frame buffer,
// looks up the palette and re-times sync/blank so they line up with colour.
module nes_vga_scaler
    import nes_vga_pkg::*;
#(
    parameter int unsigned X_OFF      = (VGA_W - 2 * NES_W) / 2,
    parameter rgb_t        BORDER_RGB = 24'h000000,
    parameter int unsigned FB_AW      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             blank_n_in,
    output logic             fb_rd_en,
    output logic [FB_AW-1:0] fb_addr,
    input  logic [IDX_W-1:0] fb_data,
    output logic [CH_W-1:0]  red,
    output logic [CH_W-1:0]  green,
    output logic [CH_W-1:0]  blue,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             blank_n_out
);

    localparam logic [XCNT_W-1:0] X_LO  = XCNT_W'(X_OFF);
    localparam logic [XCNT_W-1:0] X_HI  = XCNT_W'(X_OFF + 2 * NES_W);
    localparam logic [XCNT_W-1:0] X_MAX = '1;
    localparam logic [YCNT_W-1:0] Y_LIM = YCNT_W'(VGA_H);
    localparam logic [YCNT_W-1:0] Y_MAX = '1;

    logic [XCNT_W-1:0] x_cnt_q, x_cnt_d;
    logic [YCNT_W-1:0] y_cnt_q, y_cnt_d;
    logic              synced_q, synced_d;
    logic              vs_fall_c, bl_fall_c, win_c;

    tap_t              s1_q, s1_d;
    tap_t              s2_q;
    logic              fb_rd_en_q;
    logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;

    rgb_t              pal_rgb_c;
    rgb_t              rgb_q, rgb_d;
    logic              hsync_q, vsync_q, blank_n_q;

    // Edges are taken against the stage-1 taps, which hold last cycle's inputs.
    always_comb begin : count_comb
        vs_fall_c = s1_q.vsync & ~vsync_in;
        bl_fall_c = s1_q.blank_n & ~blank_n_in;

        x_cnt_d = '0;
        if (blank_n_in) begin
            x_cnt_d = (x_cnt_q == X_MAX) ? x_cnt_q : x_cnt_q + XCNT_W'(1);
        end

        y_cnt_d = y_cnt_q;
        if (vs_fall_c) begin
            y_cnt_d = '0;
        end else if (bl_fall_c && (y_cnt_q != Y_MAX)) begin
            y_cnt_d = y_cnt_q + YCNT_W'(1);
        end

        synced_d = synced_q | vs_fall_c;
    end

    // Until the first vsync the row count is meaningless, so the window stays shut.
    assign win_c = synced_q & blank_n_in
                 & (x_cnt_q >= X_LO) & (x_cnt_q < X_HI)
                 & (y_cnt_q < Y_LIM);

    always_comb begin : fetch_comb
        s1_d      = '{hsync: hsync_in, vsync: vsync_in, blank_n: blank_n_in, win: win_c};
        fb_addr_d = fb_addr_q;
        if (win_c) begin
            fb_addr_d = FB_AW'({ROW_W'(y_cnt_q >> 1), COL_W'((x_cnt_q - X_LO) >> 1)});
        end
    end

    nes_palette_rom u_palette (
        .idx_i   (fb_data),
        .rgb_c_o (pal_rgb_c)
    );

    always_comb begin : colour_comb
        rgb_d = '0;
        if (s2_q.blank_n) begin
            rgb_d = s2_q.win ? pal_rgb_c : BORDER_RGB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : count_ff
        if (!rst_n) begin
            x_cnt_q  <= '0;
            y_cnt_q  <= '0;
            synced_q <= 1'b0;
        end else begin
            x_cnt_q  <= x_cnt_d;
            y_cnt_q  <= y_cnt_d;
            synced_q <= synced_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : pipe_ff
        if (!rst_n) begin
            s1_q       <= TAP_IDLE;
            s2_q       <= TAP_IDLE;
            fb_rd_en_q <= 1'b0;
            fb_addr_q  <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s1_q;
            fb_rd_en_q <= win_c;
            fb_addr_q  <= fb_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : out_ff
        if (!rst_n) begin
            rgb_q     <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            hsync_q   <= s2_q.hsync;
            vsync_q   <= s2_q.vsync;
            blank_n_q <= s2_q.blank_n;
        end
    end

    assign fb_rd_en    = fb_rd_en_q;
    assign fb_addr     = fb_addr_q;
    assign red         = rgb_q.r;
    assign green       = rgb_q.g;
    assign blue        = rgb_q.b;
    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign blank_n_out = blank_n_q;

endmodule

// File: tb/tb_nes_vga_scaler.sv
// Randomised raster stimulus against a behavioural scaler model, plus pinned literal checks.
module tb_nes_vga_scaler;

    localparam int          X_OFF  = 64;
    localparam logic [23:0] BORDER = 24'h202020;

    localparam logic [23:0] PAL [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        bl;
        logic        win;
        logic [15:0] addr;
    } pix_t;

    localparam pix_t IDLE = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, win: 1'b0, addr: 16'h0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        blank_n_in = 1'b0;
    logic        fb_rd_en;
    logic [15:0] fb_addr;
    logic [5:0]  fb_data = 6'h0;
    logic [7:0]  red, green, blue;
    logic        hsync_out, vsync_out, blank_n_out;

    int n_cmp = 0;
    int n_bad = 0;

    nes_vga_scaler #(
        .X_OFF      (X_OFF),
        .BORDER_RGB (BORDER),
        .FB_AW      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .blank_n_in  (blank_n_in),
        .fb_rd_en    (fb_rd_en),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .blank_n_out (blank_n_out)
    );

    always #5 clk = ~clk;

    // Frame-buffer contents mix row and column so both address halves reach the colour.
    function automatic logic [5:0] fbmem(input logic [15:0] a);
        return 6'(a[5:0] + a[13:8]);
    endfunction

    always @(posedge clk) begin
        if (fb_rd_en) fb_data <= fbmem(fb_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: raster position from the input rules, a 2-deep pixel history for latency.
    int          mx, my;
    bit          msync, prev_vs, prev_bl;
    bit          e_rd, e_hs, e_vs, e_bl;
    logic [15:0] e_addr;
    logic [23:0] e_rgb;
    pix_t        hist[$];

    always @(posedge clk or negedge rst_n) begin
        pix_t p, o;
        bit   vf, bf;
        if (!rst_n) begin
            mx = 0; my = 0; msync = 0; prev_vs = 1; prev_bl = 0;
            e_rd = 0; e_addr = 16'h0; e_rgb = 24'h0; e_hs = 1; e_vs = 1; e_bl = 0;
            hist.delete();
            hist.push_back(IDLE);
            hist.push_back(IDLE);
        end else begin
            p.hs   = hsync_in;
            p.vs   = vsync_in;
            p.bl   = blank_n_in;
            p.win  = msync && blank_n_in && (mx >= X_OFF) && (mx < X_OFF + 512) && (my < 480);
            p.addr = p.win ? 16'((my / 2) * 256 + (mx - X_OFF) / 2) : 16'h0;
            vf = prev_vs && !vsync_in;
            bf = prev_bl && !blank_n_in;
            mx = blank_n_in ? ((mx < 1023) ? mx + 1 : 1023) : 0;
            my = vf ? 0 : (bf ? ((my < 511) ? my + 1 : 511) : my);
            msync   = msync || vf;
            prev_vs = vsync_in;
            prev_bl = blank_n_in;
            o = hist.pop_front();
            hist.push_back(p);
            e_rd = p.win;
            if (p.win) e_addr = p.addr;
            e_hs  = o.hs;
            e_vs  = o.vs;
            e_bl  = o.bl;
            e_rgb = !o.bl ? 24'h0 : (!o.win ? BORDER : PAL[fbmem(o.addr)]);
        end
    end

    always @(negedge clk) begin
        chk("fb_rd_en", 32'(fb_rd_en), 32'(e_rd));
        chk("fb_addr", 32'(fb_addr), 32'(e_addr));
        chk("rgb", 32'({red, green, blue}), 32'(e_rgb));
        chk("hsync_out", 32'(hsync_out), 32'(e_hs));
        chk("vsync_out", 32'(vsync_out), 32'(e_vs));
        chk("blank_n_out", 32'(blank_n_out), 32'(e_bl));
    end

    task automatic cyc(input logic hs, input logic vs, input logic bl);
        hsync_in   = hs;
        vsync_in   = vs;
        blank_n_in = bl;
        @(posedge clk);
        #1;
    endtask

    // mode 0: model only; 1: pinned window literals; 2: pinned "not yet synced" literals.
    task automatic line(input int act, input int hbl, input int mode, input logic [7:0] row,
                        input logic [23:0] rgb66, input int rst_col);
        for (int c = 0; c < act; c++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (rst_col >= 0 && c == rst_col) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_rd_en", 32'(fb_rd_en), 32'd0);
                chk("rst_addr", 32'(fb_addr), 32'd0);
                chk("rst_rgb", 32'({red, green, blue}), 32'd0);
                chk("rst_hsync", 32'(hsync_out), 32'd1);
                chk("rst_vsync", 32'(vsync_out), 32'd1);
                chk("rst_blank", 32'(blank_n_out), 32'd0);
            end
            if (rst_col >= 0 && c == rst_col + 2) rst_n = 1'b1;
            if (mode == 1) begin
                if (c == 63)  chk("rd_c63", 32'(fb_rd_en), 32'd0);
                if (c == 64 || c == 65) begin
                    chk("rd_c64", 32'(fb_rd_en), 32'd1);
                    chk("addr_c64", 32'(fb_addr), 32'({row, 8'h00}));
                end
                if (c == 66)  chk("addr_c66", 32'(fb_addr), 32'({row, 8'h01}));
                if (c == 575) chk("addr_c575", 32'(fb_addr), 32'({row, 8'hFF}));
                if (c == 576) chk("rd_c576", 32'(fb_rd_en), 32'd0);
                if (c == 2 || c == 579) chk("border_rgb", 32'({red, green, blue}), 32'(BORDER));
                if (c == 68)  chk("rgb_c66", 32'({red, green, blue}), 32'(rgb66));
            end else if (mode == 2) begin
                if (c == 64 || c == 300) chk("presync_rd", 32'(fb_rd_en), 32'd0);
                if (c == 100) chk("presync_rgb", 32'({red, green, blue}), 32'(BORDER));
            end
        end
        for (int c = 0; c < hbl; c++) begin
            cyc((c < 2 || c >= hbl - 2), 1'b1, 1'b0);
            if (mode != 0 && c == 2) begin
                chk("blank_rgb", 32'({red, green, blue}), 32'd0);
                chk("blank_out", 32'(blank_n_out), 32'd0);
            end
        end
    endtask

    task automatic vblank(input int n);
        for (int l = 0; l < n; l++)
            for (int c = 0; c < 40; c++)
                cyc(1'b1, !(l == 1 || l == 2), 1'b0);
    endtask

    task automatic frame(input int rst_line);
        for (int l = 0; l < 480; l++) begin
            bit full;
            int mode;
            full = (l <= 2) || (l >= 478) || (l == rst_line);
            mode = (l <= 1 || (l >= 478 && rst_line < 0)) ? 1 : 0;
            line(full ? 640 : int'($urandom_range(4, 100)), int'($urandom_range(6, 12)), mode,
                 (l >= 478) ? 8'hEF : 8'h00, (l >= 478) ? 24'hFCFCFC : 24'h0000FC,
                 (l == rst_line) ? 300 : -1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) line(640, 10, 2, 8'h00, 24'h0, -1);
        vblank(4);
        frame(-1);
        vblank(4);
        repeat (400) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        vblank(4);
        frame(100);
        vblank(4);
        line(640, 10, 1, 8'h00, 24'h0000FC, -1);
        line(640, 10, 1, 8'h00, 24'h0000FC, -1);
        vblank(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
